// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks: FSM states,
// width helpers and saturation bounds for signed fixed-point words.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } nn_state_t;

  // Ceiling log2 for elaboration-time sizing; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Wide enough that N full-scale products plus a shifted bias cannot overflow.
  function automatic int acc_width(input int word_length, input int n_inputs);
    return 2 * word_length + clog2(n_inputs) + 1;
  endfunction

  function automatic logic signed [63:0] sat_max(input int word_length);
    return (64'sd1 <<< (word_length - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int word_length);
    return -(64'sd1 <<< (word_length - 1));
  endfunction

endpackage

// File: rtl/fx_round_sat.sv
// Combinational round-half-up and saturate from a wide fixed-point
// accumulator down to a signed WORD_LENGTH result.
module fx_round_sat
  import nn_pkg::*;
#(
  parameter int ACC_WIDTH   = 33,
  parameter int WORD_LENGTH = 15,
  parameter int FRAC_BITS   = 7
) (
  input  logic signed [ACC_WIDTH-1:0]   acc,
  output logic signed [WORD_LENGTH-1:0] sat_out
);

  localparam logic signed [ACC_WIDTH:0] MAX_V = (ACC_WIDTH + 1)'(sat_max(WORD_LENGTH));
  localparam logic signed [ACC_WIDTH:0] MIN_V = (ACC_WIDTH + 1)'(sat_min(WORD_LENGTH));

  logic signed [ACC_WIDTH:0] acc_ext;
  logic signed [ACC_WIDTH:0] rounded;
  logic signed [ACC_WIDTH:0] shifted;

  // One guard bit so the rounding increment can never wrap.
  assign acc_ext = {acc[ACC_WIDTH-1], acc};

  generate
    if (FRAC_BITS > 0) begin : g_round
      localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH + 1)'(64'sd1 <<< (FRAC_BITS - 1));
      assign rounded = acc_ext + HALF;
    end else begin : g_no_round
      assign rounded = acc_ext;
    end
  endgenerate

  assign shifted = rounded >>> FRAC_BITS;

  always_comb begin
    sat_out = shifted[WORD_LENGTH-1:0];
    if (shifted > MAX_V) begin
      sat_out = MAX_V[WORD_LENGTH-1:0];
    end else if (shifted < MIN_V) begin
      sat_out = MIN_V[WORD_LENGTH-1:0];
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Serial multiply-accumulate neuron: N_INPUTS x*w beats plus a bias, rounded
// and saturated, then presented on sum_out one cycle ahead of a ready pulse.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int WORD_LENGTH = 15,
  parameter int FRAC_BITS   = 7,
  parameter int N_INPUTS    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic signed [WORD_LENGTH-1:0] bias,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [WORD_LENGTH-1:0] x,
  input  logic signed [WORD_LENGTH-1:0] w,
  output logic signed [WORD_LENGTH-1:0] sum_out,
  output logic                          ready,
  output logic                          busy
);

  localparam int ACC_WIDTH = acc_width(WORD_LENGTH, N_INPUTS);
  localparam int CNT_WIDTH = (clog2(N_INPUTS) > 0) ? clog2(N_INPUTS) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(N_INPUTS - 1);

  nn_state_t                     state;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic [CNT_WIDTH-1:0]          cnt;
  logic signed [2*WORD_LENGTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]   product_ext;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [WORD_LENGTH-1:0] rounded_word;
  logic                          beat;

  assign product     = x * w;
  assign product_ext = ACC_WIDTH'(product);
  // Bias enters the accumulator in the same Q-format as the products.
  assign bias_ext    = ACC_WIDTH'(bias) <<< FRAC_BITS;
  assign beat        = in_valid && in_ready;

  fx_round_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .WORD_LENGTH(WORD_LENGTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_round_sat (
    .acc    (acc),
    .sat_out(rounded_word)
  );

  // in_ready mirrors ACCUM exactly; busy stays up through the DONE cycle so it
  // falls only once the ready pulse has been delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      sum_out  <= '0;
      ready    <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            acc      <= bias_ext;
            cnt      <= '0;
            in_ready <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          busy <= 1'b1;
          if (beat) begin
            acc <= acc + product_ext;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              in_ready <= 1'b0;
              state    <= FINISH;
            end
          end
        end
        FINISH: begin
          sum_out <= rounded_word;
          state   <= DONE;
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Randomized and directed checks of neuron_mac against an arithmetic model
// of the weighted sum, rounding, saturation and handshake timing.
module tb_neuron_mac;

  localparam int W = 15;
  localparam int F = 7;
  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic signed [W-1:0] bias = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] x = '0;
  logic signed [W-1:0] w = '0;
  logic signed [W-1:0] sum_out;
  logic                ready;
  logic                busy;

  int     checks = 0;
  int     errors = 0;
  int     xs[N];
  int     ws[N];
  longint prev_sum = 0;

  neuron_mac #(.WORD_LENGTH(W), .FRAC_BITS(F), .N_INPUTS(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bias    (bias),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x       (x),
    .w       (w),
    .sum_out (sum_out),
    .ready   (ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: exact real-valued weighted sum in Q(F), round half up, clamp.
  function automatic longint model_eval(input longint b);
    longint a;
    a = b * (longint'(1) << F);
    for (int i = 0; i < N; i++) a += longint'(xs[i]) * longint'(ws[i]);
    if (F > 0) a += longint'(1) << (F - 1);
    a = a >>> F;
    if (a > 16383) a = 16383;
    if (a < -16384) a = -16384;
    return a;
  endfunction

  task automatic set_beats(input int x0, w0, x1, w1, x2, w2, x3, w3);
    xs[0] = x0; ws[0] = w0; xs[1] = x1; ws[1] = w1;
    xs[2] = x2; ws[2] = w2; xs[3] = x3; ws[3] = w3;
  endtask

  // One evaluation; vmask bit e-1 gives in_valid for cycle e after start.
  task automatic run_eval(input string name, input int b, input logic [15:0] vmask,
                          input int spur);
    int taken, last, rdy_cnt, rdy_edge, busy_low;
    longint exp;
    taken = 0; last = -1; rdy_cnt = 0; rdy_edge = -1; busy_low = -1;
    exp = model_eval(longint'(b));
    @(negedge clk);
    start = 1'b1; bias = W'(b); in_valid = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    check({name, ".busy_start"}, longint'(busy), 1);
    for (int e = 1; e <= 60 && busy_low < 0; e++) begin
      @(negedge clk);
      check({name, ".in_ready"}, longint'(in_ready), (taken < N) ? 1 : 0);
      if (taken < N) begin
        in_valid = (e <= 16) ? vmask[e-1] : 1'b1;
        x = W'(xs[taken]);
        w = W'(ws[taken]);
      end else begin
        in_valid = 1'($urandom);
        x = W'($urandom);
        w = W'($urandom);
      end
      start = (e == spur);
      @(posedge clk);
      if (in_valid && taken < N) begin
        taken++;
        if (taken == N) last = e;
      end
      #1;
      start = 1'b0;
      in_valid = 1'b0;
      if (ready) begin
        rdy_cnt++;
        if (rdy_edge < 0) rdy_edge = e;
      end
      if (last >= 0 && e == last) check({name, ".sum_hold"}, longint'(sum_out), prev_sum);
      if (last >= 0 && e == last + 1) check({name, ".sum_early"}, longint'(sum_out), exp);
      if (last >= 0 && !busy) busy_low = e;
    end
    repeat (2) begin
      @(posedge clk);
      #1 if (ready) rdy_cnt++;
    end
    check({name, ".ready_cycle"}, longint'(rdy_edge), longint'(last + 2));
    check({name, ".ready_pulses"}, longint'(rdy_cnt), 1);
    check({name, ".busy_low_cycle"}, longint'(busy_low), longint'(last + 3));
    check({name, ".sum_final"}, longint'(sum_out), exp);
    $display("run %s bias=%0d last_beat=%0d sum_out=%0d expected=%0d", name, b, last,
             sum_out, exp);
    prev_sum = exp;
  endtask

  initial begin
    #12;
    check("rst.sum_out", longint'(sum_out), 0);
    check("rst.ready", longint'(ready), 0);
    check("rst.busy", longint'(busy), 0);
    check("rst.in_ready", longint'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    set_beats(128, 128, 128, 128, 128, 128, 128, 128);
    run_eval("nominal", 0, 16'hFFFF, 0);
    set_beats(128, -128, 128, -128, 128, -128, 128, -128);
    run_eval("negative", -64, 16'hFFFF, 0);
    set_beats(16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383);
    run_eval("sat_pos", 16383, 16'hFFFF, 0);
    set_beats(16383, -16384, 16383, -16384, 16383, -16384, 16383, -16384);
    run_eval("sat_neg", 0, 16'hFFFF, 0);
    set_beats(1, 64, 0, 0, 0, 0, 0, 0);
    run_eval("round_half", 0, 16'hFFFF, 0);
    set_beats(1, 63, 0, 0, 0, 0, 0, 0);
    run_eval("round_below", 0, 16'hFFFF, 0);
    set_beats(-1, 64, 0, 0, 0, 0, 0, 0);
    run_eval("round_neg_half", 0, 16'hFFFF, 0);
    set_beats(128, 128, 128, 128, 128, 128, 128, 128);
    run_eval("backpressure", 0, 16'h0059, 3);

    // Abort after two beats; outputs must clear at once and stay quiet.
    set_beats(300, 700, -500, 90, 11, 12, 13, 14);
    @(negedge clk);
    start = 1'b1; bias = W'(1000);
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = W'(xs[i]); w = W'(ws[i]);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.sum_out", longint'(sum_out), 0);
    check("abort.busy", longint'(busy), 0);
    check("abort.in_ready", longint'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int rdy_seen;
      rdy_seen = 0;
      repeat (6) begin
        @(posedge clk);
        #1 if (ready) rdy_seen++;
      end
      check("abort.no_ready", longint'(rdy_seen), 0);
      check("abort.busy_after", longint'(busy), 0);
    end
    prev_sum = 0;
    set_beats(200, -300, 128, 128, -77, 5, 9, -1000);
    run_eval("after_abort", -250, 16'hFFFF, 2);

    for (int r = 0; r < 20; r++) begin
      logic [15:0] m;
      int b;
      for (int i = 0; i < N; i++) begin
        if (r % 3 == 0) begin
          xs[i] = int'($urandom_range(0, 32767)) - 16384;
          ws[i] = int'($urandom_range(0, 32767)) - 16384;
        end else begin
          xs[i] = int'($urandom_range(0, 1023)) - 512;
          ws[i] = int'($urandom_range(0, 1023)) - 512;
        end
      end
      b = int'($urandom_range(0, 32767)) - 16384;
      m = 16'($urandom) | 16'h8421;
      run_eval($sformatf("rand%0d", r), b, m, int'($urandom_range(0, 5)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
Serial multiply-accumulate neuron stage. It sits directly upstream of the ReLU activation stage and produces that stage's pre-activation input.
- Consumes N_INPUTS (input, weight) pairs, one per accepted beat, and adds a bias.
- Rounds and saturates the sum to WORD_LENGTH bits.
- Presents the result on sum_out, then pulses ready.
- Downstream samples sum_out on the rising edge of ready, so sum_out must be stable before ready rises.

Parameters:
WORD_LENGTH, 15, width of x, w, bias and sum_out; signed two's complement.
FRAC_BITS, 7, fractional bits of the fixed-point format (1.0 = 128).
N_INPUTS, 4, number of beats per neuron evaluation (must be >= 1).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset, active-low.
start  input  1  begins one evaluation; honoured in IDLE only.
bias  input  WORD_LENGTH  bias value, sampled on the accepted start.
in_valid  input  1  x/w beat valid.
in_ready  output  1  high in ACCUM; a beat is taken when in_valid && in_ready.
x  input  WORD_LENGTH  neuron input, signed.
w  input  WORD_LENGTH  weight, signed.
sum_out  output  WORD_LENGTH  rounded, saturated weighted sum; held until the next FINISH.
ready  output  1  one-cycle pulse, result valid.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, sum_out=0, ready=0, in_ready=0, busy=0, accumulator=0, beat counter=0.
- Widths:
  - Product: full 2*WORD_LENGTH signed.
  - ACC_WIDTH = 2*WORD_LENGTH + clog2(N_INPUTS) + 1; the accumulator never overflows.
- IDLE:
  - On start: acc <= sign-extended bias << FRAC_BITS; cnt <= 0; go to ACCUM.
  - in_valid in IDLE is ignored.
- ACCUM:
  - in_ready=1.
  - Each accepted beat: acc += x*w; cnt++.
  - Idle cycles (in_valid=0) stall without changing state.
  - On the beat where cnt == N_INPUTS-1: go to FINISH; in_ready drops on the next cycle.
- FINISH (1 cycle):
  - r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift, round half up).
  - Saturate r to [-2^(WORD_LENGTH-1), 2^(WORD_LENGTH-1)-1]; register into sum_out.
  - Go to DONE.
- DONE (1 cycle): ready=1; go to IDLE.
  - ready is registered and glitch-free.
  - sum_out has been stable for at least one full cycle before ready rises.
- Latency: start accepted at cycle 0 with back-to-back beats at cycles 1..N → sum_out updates at N+1, ready high at N+2, busy low at N+3.
- start while busy is ignored; a new start is accepted in the cycle after DONE (IDLE).
- Reset mid-operation: abort immediately; no ready pulse is produced; sum_out clears to 0.
- FRAC_BITS=0: no rounding term is added.

Decomposition:
- Shared package nn_pkg:
  - state enum {IDLE, ACCUM, FINISH, DONE}.
  - clog2 function.
  - ACC_WIDTH derivation.
  - Saturation min/max constants as functions of WORD_LENGTH.
- One sub-module: fx_round_sat (combinational).
  - Parameters: ACC_WIDTH, WORD_LENGTH, FRAC_BITS.
  - Input: acc. Output: saturated word.
  - Reused by later layers.

Test Plan:
1. Nominal: bias=0, four beats x=128, w=128 → sum_out=512 (0x0200); ready pulses exactly at cycle 6 after start at cycle 0; in_ready high cycles 1–4.
2. Negative: bias=-64, four beats x=128, w=-128 → sum_out=-576 (0x7DC0 in 15 bits); one ready pulse.
3. Saturation: four beats x=w=16383, bias=16383 → sum_out=16383 (0x3FFF). Four beats x=16383, w=-16384 → sum_out=-16384 (0x4000).
4. Rounding: beats (1,64),(0,0),(0,0),(0,0), bias=0 → sum_out=1. Beats (1,63)+zeros → sum_out=0. Beats (-1,64)+zeros → sum_out=0.
5. Backpressure and spurious start: in_valid pattern 1,0,0,1,1,0,1 with x=w=128; start pulsed mid-ACCUM → sum_out=512; ready at cycle 9 after start; exactly one ready pulse.
6. Reset mid-ACCUM after 2 beats: rst_n low 1 cycle → sum_out=0, busy=0, no ready pulse. A fresh run then gives the correct result with no residue from the aborted run.
